// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard unit for a five-stage in-order pipeline (IF/ID/EX/MEM/WB).
//   It keeps a small shadow of the destination information held by the EX
//   and MEM stages. From that shadow it produces registered EX operand
//   forwarding selects, the load-use stall/bubble, and the branch flush
//   controls. It also counts stall and flush events.
//
// Ports
//   i_clk            clock, all state updates on the rising edge
//   i_reset          synchronous active-high reset
//   i_valid_id       ID stage holds a real instruction
//   i_rs1_addr_id    ID source register 1 address
//   i_rs2_addr_id    ID source register 2 address
//   i_rs1_used_id    ID instruction reads rs1
//   i_rs2_used_id    ID instruction reads rs2
//   i_rd_addr_id     ID destination register
//   i_rd_wren_id     ID instruction writes rd
//   i_is_load_id     ID instruction is a load
//   i_flush          taken branch/jump resolved in EX this cycle
//   i_hold           global freeze; every pipeline register holds
//   o_forward_a/b    EX operand select: 00 regfile, 01 MEM result, 10 WB data
//   o_stall          freeze PC and IF/ID
//   o_bubble_ex      load a NOP into ID/EX on this edge
//   o_flush_if_id    invalidate IF/ID on this edge
//   o_stall_cnt      saturating count of stall cycles
//   o_flush_cnt      saturating count of flush cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid_id,
    input  logic [4:0]       i_rs1_addr_id,
    input  logic [4:0]       i_rs2_addr_id,
    input  logic             i_rs1_used_id,
    input  logic             i_rs2_used_id,
    input  logic [4:0]       i_rd_addr_id,
    input  logic             i_rd_wren_id,
    input  logic             i_is_load_id,
    input  logic             i_flush,
    input  logic             i_hold,
    output logic [1:0]       o_forward_a,
    output logic [1:0]       o_forward_b,
    output logic             o_stall,
    output logic             o_bubble_ex,
    output logic             o_flush_if_id,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        LDSTALL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Shadow of the instructions currently in EX and MEM.
    logic       ex_valid,  mem_valid;
    logic [4:0] ex_rd,     mem_rd;
    logic       ex_wren,   mem_wren;
    logic       ex_is_load, mem_is_load;

    state_t     state;

    logic       match_ex_a, match_ex_b, match_mem_a, match_mem_b;
    logic       load_use;
    logic       take_bubble;
    logic [1:0] next_fwd_a, next_fwd_b;

    // Register x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic src_match(
        input logic       used,
        input logic [4:0] src,
        input logic       st_valid,
        input logic       st_wren,
        input logic [4:0] st_rd
    );
        return used && st_valid && st_wren && (st_rd == src) && (src != 5'd0);
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        match_ex_a  = src_match(i_rs1_used_id, i_rs1_addr_id, ex_valid,  ex_wren,  ex_rd);
        match_ex_b  = src_match(i_rs2_used_id, i_rs2_addr_id, ex_valid,  ex_wren,  ex_rd);
        match_mem_a = src_match(i_rs1_used_id, i_rs1_addr_id, mem_valid, mem_wren, mem_rd);
        match_mem_b = src_match(i_rs2_used_id, i_rs2_addr_id, mem_valid, mem_wren, mem_rd);

        // A load in EX has no data yet, so a dependent instruction in ID
        // must wait one cycle and then pick the value up from WB. The FSM
        // gate limits this to a single stall per load.
        load_use = i_valid_id && ex_valid && ex_is_load
                   && (match_ex_a || match_ex_b) && (state == IDLE);

        // Bubble into EX on either a load-use or a flush (wrong-path op in ID).
        take_bubble = load_use || i_flush;

        // The nearer producer (EX, about to be in MEM) holds the newest value.
        next_fwd_a = FWD_RF;
        if (match_ex_a)       next_fwd_a = FWD_MEM;
        else if (match_mem_a) next_fwd_a = FWD_WB;

        next_fwd_b = FWD_RF;
        if (match_ex_b)       next_fwd_b = FWD_MEM;
        else if (match_mem_b) next_fwd_b = FWD_WB;

        // Flush beats stall; nothing moves while held or in reset.
        o_stall       = load_use && !i_flush && !i_hold && !i_reset;
        o_bubble_ex   = take_bubble && !i_hold && !i_reset;
        o_flush_if_id = i_flush && !i_hold && !i_reset;
    end

    // NOTE: sequential state is written with non-blocking assignments so that
    // every register samples the pre-edge values, like the real flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_valid    <= 1'b0;
            ex_rd       <= 5'd0;
            ex_wren     <= 1'b0;
            ex_is_load  <= 1'b0;
            mem_valid   <= 1'b0;
            mem_rd      <= 5'd0;
            mem_wren    <= 1'b0;
            mem_is_load <= 1'b0;
            state       <= IDLE;
            o_forward_a <= FWD_RF;
            o_forward_b <= FWD_RF;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else if (!i_hold) begin
            mem_valid   <= ex_valid;
            mem_rd      <= ex_rd;
            mem_wren    <= ex_wren;
            mem_is_load <= ex_is_load;

            if (take_bubble) begin
                ex_valid    <= 1'b0;
                ex_rd       <= 5'd0;
                ex_wren     <= 1'b0;
                ex_is_load  <= 1'b0;
                o_forward_a <= FWD_RF;
                o_forward_b <= FWD_RF;
            end else begin
                ex_valid    <= i_valid_id;
                ex_rd       <= i_rd_addr_id;
                ex_wren     <= i_rd_wren_id;
                ex_is_load  <= i_is_load_id;
                o_forward_a <= next_fwd_a;
                o_forward_b <= next_fwd_b;
            end

            case (state)
                IDLE:    state <= (load_use && !i_flush) ? LDSTALL : IDLE;
                LDSTALL: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (o_stall && (o_stall_cnt != '1))
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (i_flush && (o_flush_cnt != '1))
                o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
    end

    // Forwarding a load result from MEM (select 01) is impossible by
    // construction: the load-use stall always inserts a bubble first.
    assert property (@(posedge i_clk) disable iff (i_reset)
        !(ex_valid && mem_valid && mem_is_load
          && (o_forward_a == FWD_MEM || o_forward_b == FWD_MEM)));

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl (CNT_W = 4 so saturation is reachable).
//   Inputs change 1 time unit after the rising edge. Outputs are checked
//   after a further settle delay, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_valid_id = 1'b0;
    logic [4:0]       i_rs1_addr_id = 5'd0;
    logic [4:0]       i_rs2_addr_id = 5'd0;
    logic             i_rs1_used_id = 1'b0;
    logic             i_rs2_used_id = 1'b0;
    logic [4:0]       i_rd_addr_id = 5'd0;
    logic             i_rd_wren_id = 1'b0;
    logic             i_is_load_id = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_hold = 1'b0;
    logic [1:0]       o_forward_a, o_forward_b;
    logic             o_stall, o_bubble_ex, o_flush_if_id;
    logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_valid_id    (i_valid_id),
        .i_rs1_addr_id (i_rs1_addr_id),
        .i_rs2_addr_id (i_rs2_addr_id),
        .i_rs1_used_id (i_rs1_used_id),
        .i_rs2_used_id (i_rs2_used_id),
        .i_rd_addr_id  (i_rd_addr_id),
        .i_rd_wren_id  (i_rd_wren_id),
        .i_is_load_id  (i_is_load_id),
        .i_flush       (i_flush),
        .i_hold        (i_hold),
        .o_forward_a   (o_forward_a),
        .o_forward_b   (o_forward_b),
        .o_stall       (o_stall),
        .o_bubble_ex   (o_bubble_ex),
        .o_flush_if_id (o_flush_if_id),
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present one instruction in ID.
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic wr, input logic ld);
        i_valid_id    = v;
        i_rs1_addr_id = rs1;
        i_rs1_used_id = u1;
        i_rs2_addr_id = rs2;
        i_rs2_used_id = u2;
        i_rd_addr_id  = rd;
        i_rd_wren_id  = wr;
        i_is_load_id  = ld;
    endtask

    task automatic set_nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        set_nop();
        i_flush = 1'b0;
        i_hold  = 1'b0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", o_forward_a); end
        checks++; if (o_forward_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", o_forward_b); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        checks++; if (o_stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", o_stall_cnt); end
        checks++; if (o_flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", o_flush_cnt); end
    endtask

    // ADD x5,x1,x2 ; SUB x6,x5,x1
    task automatic test_fwd_mem();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_dep_no_stall: got %b expected 0", o_stall); end
        tick();
        set_nop();
        settle();
        checks++; if (o_forward_a !== 2'b01) begin errors++; $display("FAIL mem_fwd_a: got %b expected 01", o_forward_a); end
        checks++; if (o_forward_b !== 2'b00) begin errors++; $display("FAIL mem_fwd_b: got %b expected 00", o_forward_b); end
    endtask

    // ADD x5 ; NOP ; OR x7,x1,x5   then   ADD x5 ; ADD x5 ; OR x7,x5,x5
    task automatic test_fwd_wb();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_nop();
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        settle();
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL wb_fwd_a: got %b expected 00", o_forward_a); end
        checks++; if (o_forward_b !== 2'b10) begin errors++; $display("FAIL wb_fwd_b: got %b expected 10", o_forward_b); end

        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        set_nop();
        settle();
        checks++; if (o_forward_a !== 2'b01) begin errors++; $display("FAIL nearer_fwd_a: got %b expected 01", o_forward_a); end
        checks++; if (o_forward_b !== 2'b01) begin errors++; $display("FAIL nearer_fwd_b: got %b expected 01", o_forward_b); end
    endtask

    // LW x5,0(x1) ; ADD x6,x5,x2
    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", o_stall); end
        checks++; if (o_bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b expected 1", o_bubble_ex); end
        checks++; if (o_flush_if_id !== 1'b0) begin errors++; $display("FAIL lu_no_flush: got %b expected 0", o_flush_if_id); end
        tick();
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %b expected 0", o_stall); end
        checks++; if (o_bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_bubble_drop: got %b expected 0", o_bubble_ex); end
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd: got %b expected 00", o_forward_a); end
        tick();
        set_nop();
        settle();
        checks++; if (o_forward_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b expected 10", o_forward_a); end
        checks++; if (o_forward_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b expected 00", o_forward_b); end
        checks++; if (o_stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", o_stall_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        tick();
        settle();
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL x0_fwd_a: got %b expected 00", o_forward_a); end
        checks++; if (o_forward_b !== 2'b00) begin errors++; $display("FAIL x0_fwd_b: got %b expected 00", o_forward_b); end
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL x0_load_no_stall: got %b expected 0", o_stall); end
        tick();
        set_nop();
    endtask

    task automatic test_flush_beats_stall();
        do_reset();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        i_flush = 1'b1;
        settle();
        checks++; if (o_flush_if_id !== 1'b1) begin errors++; $display("FAIL fl_flush_if_id: got %b expected 1", o_flush_if_id); end
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b expected 0", o_stall); end
        checks++; if (o_bubble_ex !== 1'b1) begin errors++; $display("FAIL fl_bubble: got %b expected 1", o_bubble_ex); end
        tick();
        i_flush = 1'b0;
        set_nop();
        settle();
        checks++; if (o_flush_cnt !== 4'd1) begin errors++; $display("FAIL fl_flush_cnt: got %0d expected 1", o_flush_cnt); end
        checks++; if (o_stall_cnt !== 4'd0) begin errors++; $display("FAIL fl_stall_cnt: got %0d expected 0", o_stall_cnt); end
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL fl_fwd_a: got %b expected 00", o_forward_a); end
    endtask

    // ADD x1 ; LW x5,0(x1) ; ADD x6,x5,x2 with a 3-cycle hold on the stall
    task automatic test_hold();
        do_reset();
        set_id(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        checks++; if (o_forward_a !== 2'b01) begin errors++; $display("FAIL hold_pre_fwd_a: got %b expected 01", o_forward_a); end
        i_hold = 1'b1;
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL hold_stall_masked: got %b expected 0", o_stall); end
        checks++; if (o_bubble_ex !== 1'b0) begin errors++; $display("FAIL hold_bubble_masked: got %b expected 0", o_bubble_ex); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_forward_a !== 2'b01) begin errors++; $display("FAIL hold_fwd_frozen[%0d]: got %b expected 01", i, o_forward_a); end
            checks++; if (o_stall_cnt !== 4'd0) begin errors++; $display("FAIL hold_cnt_frozen[%0d]: got %0d expected 0", i, o_stall_cnt); end
        end
        i_hold = 1'b0;
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL hold_release_stall: got %b expected 1", o_stall); end
        tick();
        settle();
        checks++; if (o_stall_cnt !== 4'd1) begin errors++; $display("FAIL hold_stall_cnt: got %0d expected 1", o_stall_cnt); end
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL hold_bubble_fwd: got %b expected 00", o_forward_a); end
        tick();
        set_nop();
        settle();
        checks++; if (o_forward_a !== 2'b10) begin errors++; $display("FAIL hold_final_fwd: got %b expected 10", o_forward_a); end
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
            tick();
            tick();
            if (n == 15) begin
                checks++; if (o_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_15: got %0d expected 15", o_stall_cnt); end
            end
        end
        checks++; if (o_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_16: got %0d expected 15", o_stall_cnt); end
        set_nop();
        i_flush = 1'b1;
        repeat (20) tick();
        i_flush = 1'b0;
        checks++; if (o_flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush: got %0d expected 15", o_flush_cnt); end

        // Enter LDSTALL, then reset with hold and flush also asserted.
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        i_reset = 1'b1;
        i_hold  = 1'b1;
        i_flush = 1'b1;
        settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", o_stall); end
        checks++; if (o_bubble_ex !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b expected 0", o_bubble_ex); end
        checks++; if (o_flush_if_id !== 1'b0) begin errors++; $display("FAIL rst_flush_if_id: got %b expected 0", o_flush_if_id); end
        tick();
        i_reset = 1'b0;
        i_hold  = 1'b0;
        i_flush = 1'b0;
        set_nop();
        settle();
        checks++; if (o_forward_a !== 2'b00) begin errors++; $display("FAIL rst_fwd_a: got %b expected 00", o_forward_a); end
        checks++; if (o_stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", o_stall_cnt); end
        checks++; if (o_flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_flush_cnt: got %0d expected 0", o_flush_cnt); end
        // A fresh load-use right after reset must stall again (FSM back in IDLE).
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rst_idle_stall: got %b expected 1", o_stall); end
        tick();
        set_nop();
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_load_use();
        test_x0();
        test_flush_beats_stall();
        test_hold();
        test_saturation_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
